// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
// State encodings, byte-enable width and the legal wait-state range.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_BUSY = 2'd1,
    DMR_DONE = 2'd2
  } dmr_state_e;

  localparam int unsigned DMR_BE_W    = 4;
  localparam int unsigned DMR_LAT_MIN = 1;
  localparam int unsigned DMR_LAT_MAX = 15;

endpackage

// File: rtl/dmem_en_reg.sv
// Enable register cell: synchronous active-low clear, load when en is high.
module dmem_en_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dmem_sram_array.sv
// Single-port word array with byte-lane write enables and a registered read port.
// Read data only updates on an enabled access with no byte enables set.
module dmem_sram_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic [DMR_BE_W-1:0] wen,
  input  logic [AW-1:0]       addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < DMR_BE_W; k++) begin
        if (wen[k]) begin
          mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
      if (wen == '0) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-SRAM responder for the MEM stage: holds the pipeline for LAT wait states,
// then presents load data in the single DONE cycle where stall_o is low.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AW  = 10,
  parameter int unsigned LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic [DMR_BE_W-1:0] wen_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  input  logic                flush_i,
  output logic [31:0]         rdata_o,
  output logic                stall_o
);

  localparam int unsigned LAT_C = (LAT < DMR_LAT_MIN) ? DMR_LAT_MIN :
                                  (LAT > DMR_LAT_MAX) ? DMR_LAT_MAX : LAT;
  localparam logic [3:0]  CNT_INIT = 4'(LAT_C - 1);
  localparam int unsigned REQ_W    = AW + DMR_BE_W + 32;

  dmr_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         rdata_q;
  logic [REQ_W-1:0]    req_q;
  logic [AW-1:0]       addr_q;
  logic [DMR_BE_W-1:0] wen_q;
  logic [31:0]         wdata_q;
  logic                accept, busy_fire, read_flush, mem_en;
  logic [AW-1:0]       mem_addr;
  logic [DMR_BE_W-1:0] mem_wen;
  logic [31:0]         mem_wdata, mem_rdata;
  logic                unused_addr;

  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

  assign accept     = (state_q == DMR_IDLE) && req_i && !flush_i;
  assign read_flush = (state_q == DMR_BUSY) && flush_i && (wen_q == '0);
  assign busy_fire  = (state_q == DMR_BUSY) && (cnt_q == 4'd1) && !read_flush;

  // With one wait state the access fires on the accept edge, before the latch is valid.
  assign mem_en    = rst_n && (busy_fire || (accept && (LAT_C == 1)));
  assign mem_addr  = accept ? addr_i[AW+1:2] : addr_q;
  assign mem_wen   = accept ? wen_i : wen_q;
  assign mem_wdata = accept ? wdata_i : wdata_q;

  dmem_en_reg #(
    .W(REQ_W)
  ) u_req_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .d    ({addr_i[AW+1:2], wen_i, wdata_i}),
    .q    (req_q)
  );

  assign {addr_q, wen_q, wdata_q} = req_q;

  dmem_sram_array #(
    .AW(AW)
  ) u_array (
    .clk  (clk),
    .en   (mem_en),
    .wen  (mem_wen),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DMR_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == DMR_DONE) begin
        rdata_q <= rdata_o;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DMR_IDLE: begin
        if (accept) begin
          cnt_d   = CNT_INIT;
          state_d = (LAT_C == 1) ? DMR_DONE : DMR_BUSY;
        end
      end
      DMR_BUSY: begin
        if (read_flush) begin
          cnt_d   = 4'd0;
          state_d = DMR_IDLE;
        end else if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = DMR_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DMR_DONE: state_d = DMR_IDLE;
      default:  state_d = DMR_IDLE;
    endcase
  end

  always_comb begin
    stall_o = accept || (state_q == DMR_BUSY);
    rdata_o = rdata_q;
    if (state_q == DMR_DONE) begin
      rdata_o = (wen_q != '0) ? 32'd0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances at LAT 2, 1 and 15.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        req   [3];
  logic [3:0]  wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        flush [3];
  logic [31:0] rdata [3];
  logic        stall [3];

  int          lat_of [3] = '{2, 1, 15};
  logic [31:0] model [3][1024];
  logic [31:0] last  [3];
  logic [31:0] sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.AW(10), .LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n[0]), .req_i(req[0]), .wen_i(wen[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .flush_i(flush[0]), .rdata_o(rdata[0]), .stall_o(stall[0])
  );
  dmem_responder #(.AW(10), .LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n[1]), .req_i(req[1]), .wen_i(wen[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .flush_i(flush[1]), .rdata_o(rdata[1]), .stall_o(stall[1])
  );
  dmem_responder #(.AW(10), .LAT(15)) u_lat15 (
    .clk(clk), .rst_n(rst_n[2]), .req_i(req[2]), .wen_i(wen[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .flush_i(flush[2]), .rdata_o(rdata[2]), .stall_o(stall[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge ending DONE (or the flush).
  task automatic do_access(input int d, input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] wd, input int flush_at);
    logic [31:0] exp;
    logic [9:0]  idx;
    bit          flushed_read;
    int          c;
    idx          = a[11:2];
    flushed_read = (flush_at >= 0) && (w == 4'b0000);
    if (!flushed_read) begin
      if (w == 4'b0000) begin
        exp = model[d][idx];
      end else begin
        exp = 32'd0;
        for (int k = 0; k < 4; k++) begin
          if (w[k]) model[d][idx][8*k +: 8] = wd[8*k +: 8];
        end
      end
      sb.push_back(exp);
    end
    req[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    c = 0;
    while (c <= 40) begin
      @(negedge clk);
      if (!stall[d]) break;
      if (c == flush_at) flush[d] = 1'b1;
      c++;
    end
    if (flushed_read) begin
      check_eq("flush_stall_len", 32'(c), 32'(flush_at + 1));
      check_eq("flush_rdata_hold", rdata[d], last[d]);
    end else begin
      check_eq("stall_len", 32'(c), 32'(lat_of[d]));
      if (sb.size() == 0) begin
        check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
        exp = sb.pop_front();
        check_eq("rdata", rdata[d], exp);
        last[d] = exp;
      end
    end
    @(posedge clk);
    #1;
    req[d] = 1'b0; flush[d] = 1'b0; wen[d] = 4'b0000;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; wen[d] = 4'b0000; addr[d] = '0;
      wdata[d] = '0; flush[d] = 1'b0; last[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq("reset_stall", 32'(stall[d]), 32'd0);
      check_eq("reset_rdata", rdata[d], 32'd0);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    // LAT=2 full write then read
    do_access(0, 4'b1111, 32'h10, 32'hDEADBEEF, -1);
    do_access(0, 4'b0000, 32'h10, 32'h0, -1);
    // Low address bits ignored
    do_access(0, 4'b0000, 32'h13, 32'h0, -1);
    // Byte merge
    do_access(0, 4'b1111, 32'h20, 32'h11223344, -1);
    do_access(0, 4'b0010, 32'h20, 32'h0000AB00, -1);
    do_access(0, 4'b0000, 32'h20, 32'h0, -1);
    check_eq("merge_value", last[0], 32'h1122AB44);
    // LAT=1 and LAT=15
    do_access(1, 4'b1111, 32'h30, 32'hCAFEF00D, -1);
    do_access(1, 4'b0000, 32'h30, 32'h0, -1);
    do_access(2, 4'b1111, 32'h30, 32'h01234567, -1);
    do_access(2, 4'b0000, 32'h30, 32'h0, -1);
    // Flush during a read leaves rdata unchanged
    do_access(0, 4'b1111, 32'h50, 32'hA5A5A5A5, -1);
    do_access(0, 4'b1111, 32'h54, 32'h12345678, -1);
    do_access(0, 4'b0000, 32'h50, 32'h0, -1);
    do_access(0, 4'b0000, 32'h54, 32'h0, 1);
    do_access(0, 4'b0000, 32'h54, 32'h0, -1);
    // Flush during a write is ignored
    do_access(2, 4'b1111, 32'h60, 32'h600DCAFE, 3);
    do_access(2, 4'b0000, 32'h60, 32'h0, -1);
    // Aliasing modulo 2**AW words
    do_access(0, 4'b1111, 32'h1000, 32'h77665544, -1);
    do_access(0, 4'b0000, 32'h0000, 32'h0, -1);
    check_eq("alias_value", last[0], 32'h77665544);

    // Reset in the last BUSY cycle of a write discards it
    do_access(0, 4'b1111, 32'h40, 32'h0BADF00D, -1);
    req[0] = 1'b1; wen[0] = 4'b1111; addr[0] = 32'h40; wdata[0] = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    req[0] = 1'b0; wen[0] = 4'b0000;
    @(negedge clk);
    check_eq("rst_busy_stall", 32'(stall[0]), 32'd0);
    check_eq("rst_busy_rdata", rdata[0], 32'd0);
    last[0] = 32'd0;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    do_access(0, 4'b0000, 32'h40, 32'h0, -1);
    check_eq("rst_write_dropped", last[0], 32'h0BADF00D);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder at the data-SRAM end of the MEM-stage load/store interface.
- Accepts one word-wide request: address, per-byte write enables and write data.
- Holds the pipeline via stall_o for a programmable number of wait states.
- Returns load data on rdata_o, which feeds the MEM stage's memory-data input, in the cycle stall_o drops.
- Contains its own word-addressed storage array; it also serves as the bench/FPGA data memory until a cache exists.

Parameters:
- AW, 10, word-address width; array depth is 2**AW words.
- LAT, 2, wait cycles per access, legal range 1..15.

Ports:
- clk  in  1  clock; rising edge only.
- rst_n  in  1  reset; synchronous, active-low.
- req_i  in  1  access request; held stable by the requester while stall_o=1.
- wen_i  in  4  byte write enables; bit k writes wdata_i[8k+7:8k]; 0000 means read.
- addr_i  in  32  byte address; bits [AW+1:2] select the word.
- wdata_i  in  32  store data, already byte-lane aligned by the requester.
- flush_i  in  1  pipeline flush; aborts an in-flight read.
- rdata_o  out  32  load data; valid in the DONE cycle.
- stall_o  out  1  pipeline hold request.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, counter=0, rdata_o=0, stall_o=0.
  - Latched request registers are cleared.
  - Array contents are not reset.
  - Reset during BUSY discards the pending access; a pending write is never performed.
- States: IDLE, BUSY, DONE. The 4-bit counter counts down.
- stall_o = (state==IDLE & req_i & ~flush_i) | (state==BUSY). It is combinational, so the stall is seen in the acceptance cycle.
- IDLE:
  - If req_i & ~flush_i: latch addr, wen and wdata; counter <= LAT-1.
  - If LAT==1, go directly to DONE and perform the access on this edge. Otherwise go to BUSY.
- BUSY:
  - If counter != 1: counter decrements each cycle.
  - If counter == 1: perform the access and go to DONE.
  - A read is performed as: rdata_o <= array[word].
  - A write is performed as: only enabled bytes of array[word] are updated, and rdata_o <= 0.
- Timing: request accepted in cycle T → stall_o high in cycles T..T+LAT-1; DONE occupies cycle T+LAT.
- DONE:
  - stall_o=0 and rdata_o holds the result; the MEM stage captures it at the end of this cycle.
  - req_i is ignored in DONE; it is still the same request.
  - Next state is always IDLE. Peak throughput is one access per LAT+1 cycles.
- rdata_o holds its value outside DONE until the next access completes.
- flush_i:
  - In IDLE it suppresses acceptance.
  - In BUSY with wen==0 it returns the block to IDLE next cycle; stall_o stays high in that cycle and rdata_o is unchanged.
  - In BUSY with wen!=0 it is ignored; a committed store always completes.
  - In DONE it is ignored.
- Address handling:
  - addr_i[1:0] is ignored; misalignment is the requester's responsibility.
  - Bits above AW+1 are ignored, so addresses alias modulo 2**AW words.
- Simultaneous req_i and flush_i in IDLE: flush wins; nothing is accepted and stall_o=0.
- Read and write both use the same latency.

Decomposition:
- Shared defines file:
  - state encodings DMR_IDLE=2'd0, DMR_BUSY=2'd1, DMR_DONE=2'd2;
  - the byte-enable width constant;
  - the LAT range limits.
- The storage array is a natural sub-module, dmem_sram_array:
  - single port; synchronous write with 4 byte enables; synchronous read;
  - ports clk, en, wen[3:0], addr[AW-1:0], wdata, rdata.
- The FSM and counter live in dmem_responder.
- The project's enable-register cell is used for the latched request.

Test Plan:
- LAT=2 write: wen=1111, addr=0x10, wdata=0xDEADBEEF, then a read of 0x10 → stall_o high 2 cycles each; read DONE shows rdata_o=0xDEADBEEF.
- Byte merge: word 0x20=0x11223344, then write wen=0010 with wdata=0x0000AB00 → read returns 0x1122AB44.
- LAT=1 read: stall_o high exactly 1 cycle, DONE on the next cycle. LAT=15 read: stall_o high exactly 15 cycles.
- Flush in BUSY: flush_i pulses during a read → IDLE next cycle, rdata_o unchanged. Same flush during a write → write completes, array updated.
- Alias and reset:
  - With AW=10, a write to 0x1000 followed by a read of 0x0000 returns the written data.
  - rst_n=0 mid-BUSY write → stall_o=0 and rdata_o=0 next cycle; the target word is unchanged.
